// File: rtl/lfsr_rand.sv
// XNOR-feedback LFSR random source with lockup guard and a rejection-sampled draw port.
// Latency: seed/step visible next cycle; draw result 2..MAX_TRIES+1 cycles after the request.
// Backpressure: requests are ignored while o_Busy is high; results are one-cycle pulses with no stall.
module lfsr_rand #(
  parameter int WIDTH     = 8,
  parameter int OUT_W     = 4,
  parameter int RANGE     = 9,
  parameter int MAX_TRIES = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Enable,
  input  logic             i_Seed_DV,
  input  logic [WIDTH-1:0] i_Seed_Data,
  output logic [WIDTH-1:0] o_LFSR_Data,
  output logic             o_LFSR_Done,
  input  logic             i_Draw_Req,
  output logic             o_Busy,
  output logic             o_Draw_Valid,
  output logic [OUT_W-1:0] o_Draw_Data,
  output logic             o_Draw_Fallback
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  // Tap masks: bit (n-1) set for tap n, maximal-length XNOR taps for 3..16 bits.
  function automatic logic [15:0] tap_mask(input int w);
    case (w)
      3:       tap_mask = 16'h0006;
      4:       tap_mask = 16'h000C;
      5:       tap_mask = 16'h0014;
      6:       tap_mask = 16'h0030;
      7:       tap_mask = 16'h0060;
      8:       tap_mask = 16'h00B8;
      9:       tap_mask = 16'h0110;
      10:      tap_mask = 16'h0240;
      11:      tap_mask = 16'h0500;
      12:      tap_mask = 16'h0829;
      13:      tap_mask = 16'h100D;
      14:      tap_mask = 16'h2015;
      15:      tap_mask = 16'h6000;
      16:      tap_mask = 16'hD008;
      default: tap_mask = 16'h0000;
    endcase
  endfunction

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(tap_mask(WIDTH));
  localparam logic [WIDTH-1:0] ONES = '1;

  typedef enum logic {IDLE = 1'b0, SEARCH = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   r_lfsr;
  logic [WIDTH-1:0]   r_seed;
  logic               r_stepped;
  logic [TRY_W-1:0]   r_tries, tries_d, tries_inc;
  logic               fb;
  logic               do_step;
  logic [WIDTH-1:0]   step_val;
  logic [WIDTH-1:0]   seed_val;
  logic [OUT_W-1:0]   cand;
  logic [31:0]        cand_ext;
  logic               accept;
  logic               vld_d;
  logic [OUT_W-1:0]   dat_d;
  logic               fbk_d;

  // All-ones is the XNOR lockup state, so it is mapped to zero both on load and on step.
  assign fb        = ~^(r_lfsr & TAPS);
  assign step_val  = (r_lfsr == ONES) ? '0 : {r_lfsr[WIDTH-2:0], fb};
  assign seed_val  = (i_Seed_Data == ONES) ? '0 : i_Seed_Data;
  assign do_step   = i_Enable | (state_q == SEARCH);

  assign cand      = r_lfsr[OUT_W-1:0];
  assign cand_ext  = 32'(cand);
  assign accept    = cand_ext < 32'(RANGE);
  assign tries_inc = r_tries + TRY_W'(1);

  assign o_LFSR_Data = r_lfsr;
  assign o_LFSR_Done = r_stepped & (r_lfsr == r_seed);
  assign o_Busy      = (state_q == SEARCH);

  // LFSR state, seed copy and stepped flag: reset, then seed load, then step, else hold.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_lfsr    <= '0;
      r_seed    <= '0;
      r_stepped <= 1'b0;
    end else if (i_Seed_DV) begin
      r_lfsr    <= seed_val;
      r_seed    <= seed_val;
      r_stepped <= 1'b0;
    end else if (do_step) begin
      r_lfsr    <= step_val;
      r_stepped <= 1'b1;
    end else if (r_lfsr == ONES) begin
      r_lfsr    <= '0;
    end
  end

  // Draw FSM next state: test the current low bits each SEARCH cycle, give up after MAX_TRIES.
  always_comb begin
    state_d = state_q;
    tries_d = r_tries;
    vld_d   = 1'b0;
    dat_d   = o_Draw_Data;
    fbk_d   = o_Draw_Fallback;
    case (state_q)
      IDLE: begin
        if (i_Draw_Req) begin
          state_d = SEARCH;
          tries_d = '0;
        end
      end
      SEARCH: begin
        if (accept) begin
          vld_d   = 1'b1;
          dat_d   = cand;
          fbk_d   = 1'b0;
          state_d = IDLE;
        end else begin
          tries_d = tries_inc;
          if (tries_inc == TRY_W'(MAX_TRIES)) begin
            vld_d   = 1'b1;
            dat_d   = '0;
            fbk_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Draw FSM state, try counter and registered result outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q         <= IDLE;
      r_tries         <= '0;
      o_Draw_Valid    <= 1'b0;
      o_Draw_Data     <= '0;
      o_Draw_Fallback <= 1'b0;
    end else begin
      state_q         <= state_d;
      r_tries         <= tries_d;
      o_Draw_Valid    <= vld_d;
      o_Draw_Data     <= dat_d;
      o_Draw_Fallback <= fbk_d;
    end
  end

endmodule

// File: doc/lfsr_rand.md
# lfsr_rand

Parametrised XNOR-feedback LFSR for the game's random source, generalising the fixed 4-bit LFSR to 3–16 bits. It adds all-ones lockup protection and a registered period-complete flag. It also adds a request/valid draw port that returns a uniformly distributed value in [0, RANGE-1] by rejection sampling. The AI move selector uses this port to pick a board cell (RANGE = 9).

## Interface
- WIDTH, 8, LFSR length in bits; legal range 3–16.
- OUT_W, 4, draw result width; must satisfy OUT_W ≤ WIDTH.
- RANGE, 9, exclusive upper bound of a draw; must satisfy 1 ≤ RANGE ≤ 2^OUT_W.
- MAX_TRIES, 16, number of rejections allowed before a fallback result; must be ≥ 1.
- i_Clk  in  1  clock; all logic is on its rising edge.
- i_Rst  in  1  synchronous reset, active-high.
- i_Enable  in  1  free-run step enable.
- i_Seed_DV  in  1  seed load strobe.
- i_Seed_Data  in  WIDTH  seed value.
- o_LFSR_Data  out  WIDTH  current LFSR state.
- o_LFSR_Done  out  1  high while the state equals the last seed after at least one step.
- i_Draw_Req  in  1  draw request; sampled only in IDLE.
- o_Busy  out  1  high while in SEARCH.
- o_Draw_Valid  out  1  one-cycle result pulse.
- o_Draw_Data  out  OUT_W  draw result; holds its value between pulses.
- o_Draw_Fallback  out  1  qualifies o_Draw_Valid; set when the result came from the MAX_TRIES fallback.

## Operation
- State s[WIDTH-1:0]. Step rule: s ← {s[WIDTH-2:0], fb}, where fb = XNOR of the tap bits. Tap n means s[n-1].
- Taps by WIDTH (XAPP052):
  - 3:(3,2), 4:(4,3), 5:(5,3), 6:(6,5), 7:(7,6)
  - 8:(8,6,5,4), 9:(9,5), 10:(10,7), 11:(11,9)
  - 12:(12,6,4,1), 13:(13,4,3,1), 14:(14,5,3,1)
  - 15:(15,14), 16:(16,15,13,4)
- Sequence period is 2^WIDTH-1.
- Lockup protection: all-ones is the XNOR lockup state and is never held.
  - A seed of all-ones loads 0 instead.
  - If s is ever all-ones, the next update forces 0.
- Update priority each cycle:
  1. i_Rst
  2. seed load (i_Seed_DV=1; i_Enable not required)
  3. step, when i_Enable=1 or the FSM is in SEARCH
  4. hold
- Only one step occurs per cycle, even when i_Enable=1 during SEARCH.
- Seed register r_Seed captures the loaded value after the all-ones substitution. Each load clears flag r_Stepped; any step sets it.
- o_LFSR_Done = r_Stepped & (s == r_Seed). It is combinational from registers.
- Draw FSM has two states, IDLE and SEARCH.
  - IDLE → SEARCH when i_Draw_Req=1. The try counter clears on entry.
  - In SEARCH, each cycle forms candidate c = s[OUT_W-1:0] from the current state; the LFSR steps at the end of that same cycle.
  - If c < RANGE (accept): next cycle o_Draw_Valid=1, o_Draw_Data=c, o_Draw_Fallback=0; FSM → IDLE.
  - If c ≥ RANGE (reject): the try counter increments. When the counter reaches MAX_TRIES: next cycle o_Draw_Valid=1, o_Draw_Data=0, o_Draw_Fallback=1; FSM → IDLE.
- i_Draw_Req is ignored while o_Busy=1.
- A seed load during SEARCH overrides that cycle's step. The search continues from the new state.
- Try counter width is clog2(MAX_TRIES+1).
- Reset values:
  - s = 0, r_Seed = 0, r_Stepped = 0, FSM = IDLE
  - o_Busy = 0, o_Draw_Valid = 0, o_Draw_Data = 0, o_Draw_Fallback = 0, o_LFSR_Done = 0
- Reset mid-SEARCH aborts the search. No o_Draw_Valid is issued for the aborted request.

## Timing
- Seed load or step: o_LFSR_Data reflects the new state one cycle after the strobe.
- Draw request sampled in IDLE at cycle t:
  - o_Busy=1 for cycles t+1 … t+1+k, where k is the number of rejections.
  - o_Draw_Valid=1 at cycle t+2+k. Minimum latency is 2 cycles.
  - Worst case: o_Draw_Valid at t+1+MAX_TRIES, with o_Draw_Fallback=1.
- A new request may be sampled in the same cycle o_Draw_Valid=1 (FSM is already IDLE).
- o_Draw_Fallback is meaningful only while o_Draw_Valid=1. It holds until the next pulse.

## Test plan
- Sequence check: WIDTH=4, reset, i_Enable=1 for 15 cycles.
  - Required: o_LFSR_Data = 0,1,3,7,E,D,… with period 15, and never F.
  - Required: o_LFSR_Done=1 only on the 15th step, when the state returns to 0.
- Lockup: WIDTH=4, seed 4'hF → o_LFSR_Data=0 next cycle; stepping then gives 1.
- Accept path: WIDTH=4, OUT_W=4, RANGE=9, seed 0, i_Enable=0, request at t.
  - Required: o_Draw_Valid at t+2, data 0, fallback 0.
  - Immediate second request: data 1.
- Rejection path: same parameters, seed E, request at t.
  - Candidates E, D, B are rejected; 6 is accepted.
  - Required: o_Draw_Valid at t+5, data 6; o_LFSR_Data afterwards = C.
- Fallback: MAX_TRIES=2, seed E, request at t.
  - Required: o_Draw_Valid at t+3, data 0, o_Draw_Fallback=1.
- Reset and seed during SEARCH:
  - i_Rst at t+2 of a rejecting search → o_Busy=0 next cycle, no Valid, state 0.
  - Seed 3 during SEARCH → accepted result is 3.
